// File: rtl/decode_iter_if.sv
// Handshake and datapath-control bundle between the decoder iteration
// sequencer (slave) and its surrounding datapath/host logic (master).
interface decode_iter_if #(
   parameter int ITER_W = 4
);
   logic              in_valid;
   logic              in_ready;
   logic [ITER_W-1:0] cfg_max_iter;
   logic              cfg_early_stop;
   logic              abort;
   logic              syndrome_ok;
   logic              llr_we;
   logic              elem_zero;
   logic              elem_we;
   logic [ITER_W-1:0] iter_idx;
   logic              busy;
   logic              out_valid;
   logic              out_ready;
   logic [ITER_W-1:0] iters_used;
   logic              early_stopped;

   modport master (
      output in_valid, cfg_max_iter, cfg_early_stop, abort, syndrome_ok, out_ready,
      input  in_ready, llr_we, elem_zero, elem_we, iter_idx, busy, out_valid,
             iters_used, early_stopped
   );

   modport slave (
      input  in_valid, cfg_max_iter, cfg_early_stop, abort, syndrome_ok, out_ready,
      output in_ready, llr_we, elem_zero, elem_we, iter_idx, busy, out_valid,
             iters_used, early_stopped
   );
endinterface

// File: rtl/decode_iter_ctrl.sv
// Iteration sequencer for the min-sum decoder: loads LLRs, steps layer
// iterations over a SETTLE-cycle multicycle path, stops on limit or syndrome.
module decode_iter_ctrl #(
   parameter int MAX_ITER = 5,
   parameter int SETTLE   = 2,
   parameter int ITER_W   = 4
) (
   input logic         clk,
   input logic         rst,
   decode_iter_if.slave bus
);
   localparam int                CNT_W    = (SETTLE > 1) ? $clog2(SETTLE) : 1;
   localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(SETTLE - 1);
   localparam logic [ITER_W-1:0] ITER_MAX = ITER_W'(MAX_ITER);
   localparam logic [ITER_W-1:0] ITER_ONE = ITER_W'(1'b1);
   localparam logic [ITER_W-1:0] ITER_ZERO = {ITER_W{1'b0}};

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_CHECK = 2'd2,
      ST_DONE  = 2'd3
   } state_t;

   state_t            state_r;
   logic [CNT_W-1:0]  settle_r;
   logic [ITER_W-1:0] iter_idx_r;
   logic [ITER_W-1:0] lim_r;
   logic [ITER_W-1:0] iters_used_r;
   logic              early_stop_en_r;
   logic              early_stopped_r;
   logic              busy_r;
   logic              out_valid_r;
   logic              in_ready_r;
   logic              elem_zero_r;

   logic              accept_s;
   logic              capture_s;
   logic              stop_hit_s;
   logic              finish_s;

   // A request of 0 still runs one iteration; larger requests saturate.
   function automatic logic [ITER_W-1:0] clamp_limit(input logic [ITER_W-1:0] req);
      logic [ITER_W-1:0] lim;
      if (req == ITER_ZERO) begin
         lim = ITER_ONE;
      end else if (req > ITER_MAX) begin
         lim = ITER_MAX;
      end else begin
         lim = req;
      end
      return lim;
   endfunction

   // Same-cycle strobes and termination decode; reset and abort mask them all.
   always_comb begin
      accept_s   = 1'b0;
      capture_s  = 1'b0;
      stop_hit_s = 1'b0;
      finish_s   = 1'b0;
      if (!rst && !bus.abort) begin
         case (state_r)
            ST_IDLE:  accept_s  = bus.in_valid;
            ST_RUN:   capture_s = (settle_r == CNT_LAST);
            ST_CHECK: begin
               stop_hit_s = early_stop_en_r & bus.syndrome_ok;
               finish_s   = stop_hit_s | (iter_idx_r == (lim_r - ITER_ONE));
            end
            default:  accept_s = 1'b0;
         endcase
      end else begin
         accept_s = 1'b0;
      end
   end

   // Sequencer state machine with all status outputs registered.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r         <= ST_IDLE;
         settle_r        <= {CNT_W{1'b0}};
         iter_idx_r      <= ITER_ZERO;
         lim_r           <= ITER_ONE;
         iters_used_r    <= ITER_ZERO;
         early_stop_en_r <= 1'b0;
         early_stopped_r <= 1'b0;
         busy_r          <= 1'b0;
         out_valid_r     <= 1'b0;
         in_ready_r      <= 1'b1;
         elem_zero_r     <= 1'b0;
      end else if (bus.abort && (state_r != ST_IDLE)) begin
         state_r         <= ST_IDLE;
         settle_r        <= {CNT_W{1'b0}};
         iter_idx_r      <= ITER_ZERO;
         iters_used_r    <= ITER_ZERO;
         early_stopped_r <= 1'b0;
         busy_r          <= 1'b0;
         out_valid_r     <= 1'b0;
         in_ready_r      <= 1'b1;
         elem_zero_r     <= 1'b0;
      end else begin
         case (state_r)
            ST_IDLE: begin
               if (accept_s) begin
                  lim_r           <= clamp_limit(bus.cfg_max_iter);
                  early_stop_en_r <= bus.cfg_early_stop;
                  iter_idx_r      <= ITER_ZERO;
                  settle_r        <= {CNT_W{1'b0}};
                  busy_r          <= 1'b1;
                  in_ready_r      <= 1'b0;
                  elem_zero_r     <= 1'b1;
                  state_r         <= ST_RUN;
               end
            end
            ST_RUN: begin
               if (capture_s) begin
                  elem_zero_r <= 1'b0;
                  state_r     <= ST_CHECK;
               end else begin
                  settle_r <= settle_r + CNT_W'(1'b1);
               end
            end
            ST_CHECK: begin
               if (finish_s) begin
                  iters_used_r    <= iter_idx_r + ITER_ONE;
                  early_stopped_r <= stop_hit_s;
                  out_valid_r     <= 1'b1;
                  state_r         <= ST_DONE;
               end else begin
                  iter_idx_r <= iter_idx_r + ITER_ONE;
                  settle_r   <= {CNT_W{1'b0}};
                  state_r    <= ST_RUN;
               end
            end
            ST_DONE: begin
               // in_ready rises only after leaving DONE, giving a one-cycle bubble.
               if (bus.out_ready) begin
                  out_valid_r <= 1'b0;
                  busy_r      <= 1'b0;
                  in_ready_r  <= 1'b1;
                  state_r     <= ST_IDLE;
               end
            end
            default: begin
               state_r     <= ST_IDLE;
               busy_r      <= 1'b0;
               out_valid_r <= 1'b0;
               in_ready_r  <= 1'b1;
               elem_zero_r <= 1'b0;
            end
         endcase
      end
   end

   assign bus.in_ready      = in_ready_r;
   assign bus.llr_we        = accept_s;
   assign bus.elem_we       = capture_s;
   assign bus.elem_zero     = elem_zero_r;
   assign bus.iter_idx      = iter_idx_r;
   assign bus.busy          = busy_r;
   assign bus.out_valid     = out_valid_r;
   assign bus.iters_used    = iters_used_r;
   assign bus.early_stopped = early_stopped_r;
endmodule

// File: doc/decode_iter_ctrl.md
Name: decode_iter_ctrl

Overview:
Iteration sequencer for the neural min-sum decoder datapath. The datapath is a combinational variable-node/check-node layer whose `proc_elem` result is fed back through an E-wide register.
- Accepts a codeword handshake and pulses the LLR-register load.
- Runs a bounded number of layer iterations, allowing SETTLE cycles per layer evaluation, and captures `proc_elem` at the end of each.
- Checks the parity syndrome after every capture and can stop early.
- Presents a done handshake to the output layer.

Parameters:
- MAX_ITER, 5: hard upper bound on iterations per codeword (1..15).
- SETTLE, 2: cycles allowed for one combinational layer evaluation (≥1); the datapath is a multicycle path of SETTLE cycles.
- ITER_W, 4: width of the iteration index and count; must satisfy 2^ITER_W > MAX_ITER.

Ports:
- clk  in  1  single clock; all logic on posedge.
- rst  in  1  synchronous reset, active-high.
- in_valid  in  1  new codeword LLRs are present on the datapath input.
- in_ready  out  1  controller can accept a codeword.
- cfg_max_iter  in  ITER_W  requested iteration limit, sampled on accept.
- cfg_early_stop  in  1  enables syndrome-based termination, sampled on accept.
- abort  in  1  drops the current codeword.
- syndrome_ok  in  1  all parity checks satisfied on the registered `proc_elem` hard decisions.
- llr_we  out  1  one-cycle load strobe for the all_llrs register.
- elem_zero  out  1  forces the `prev_proc_elem` feedback to zero (first iteration).
- elem_we  out  1  one-cycle capture strobe for the `proc_elem` register.
- iter_idx  out  ITER_W  current iteration index; selects the per-iteration bias/weight set.
- busy  out  1  high in every state except IDLE.
- out_valid  out  1  decode finished; result held stable.
- out_ready  in  1  downstream consumes the result.
- iters_used  out  ITER_W  iterations executed (1..limit); valid while out_valid.
- early_stopped  out  1  termination was caused by syndrome_ok; valid while out_valid.

Behaviour:
- Reset: rst=1 at a clock edge forces IDLE regardless of state, including mid-decode.
  - Registered outputs after reset: iter_idx=0, iters_used=0, early_stopped=0, busy=0, out_valid=0.
  - Combinational strobes: llr_we=0 and elem_we=0.
  - in_ready=1 from the first cycle after reset is released.
- Limit: lim = cfg_max_iter, latched on accept.
  - 0 is treated as 1.
  - Values above MAX_ITER are clamped to MAX_ITER.
- States: IDLE, RUN, CHECK, DONE.
- IDLE: in_ready=1.
  - On in_valid & in_ready & !abort: llr_we=1 combinationally in that same cycle. Latch lim and cfg_early_stop, clear iter_idx and the settle counter, go to RUN.
- RUN: elem_zero=1 while iter_idx==0. The settle counter counts 0..SETTLE-1.
  - When the counter reaches SETTLE-1: elem_we=1 for exactly that cycle, then go to CHECK.
- CHECK: lasts 1 cycle; syndrome_ok is sampled here, after capture.
  - If (early_stop_latched & syndrome_ok) or iter_idx==lim-1: iters_used=iter_idx+1, early_stopped = early_stop_latched & syndrome_ok, go to DONE.
  - Otherwise: iter_idx+1, clear the settle counter, go to RUN.
- DONE: out_valid=1; iters_used and early_stopped are held.
  - On out_ready: go to IDLE. in_ready stays 0 in DONE, so there is a one-cycle bubble before the next accept.
- Latency: accept in cycle T.
  - Capture k (0-based) occurs at cycle T + SETTLE + k*(SETTLE+1).
  - Full run: out_valid rises at T + lim*(SETTLE+1) + 1.
- abort: priority is rst > abort > all other conditions.
  - In RUN, CHECK or DONE: go to IDLE next cycle. No elem_we in that cycle, out_valid drops, iters_used and early_stopped are cleared.
  - In IDLE: blocks the accept.
- syndrome_ok is ignored outside CHECK.
- in_valid is ignored outside IDLE.
- iter_idx never exceeds lim-1. There is no wrap-around.

Test Plan:
- Full run: SETTLE=2, cfg_max_iter=5, cfg_early_stop=0, accept at T → elem_we at T+2, 5, 8, 11, 14; elem_zero only during T+1..T+2; out_valid at T+16; iters_used=5; early_stopped=0.
- Early stop: cfg_early_stop=1, syndrome_ok=1 in the first CHECK → out_valid at T+4, iters_used=1, early_stopped=1; syndrome_ok=1 with cfg_early_stop=0 → full 5 iterations.
- Clamping: cfg_max_iter=0 → iters_used=1; cfg_max_iter=9 → iters_used=5, iter_idx sequence 0..4.
- Back-pressure and back-to-back: hold out_ready=0 for 10 cycles → out_valid and iters_used stable, in_ready=0; release → next accept no earlier than 1 cycle after DONE exit.
- Abort/reset mid-run: abort during the 3rd RUN → IDLE next cycle, no further elem_we; rst asserted in CHECK → all outputs at reset values next cycle, accept works afterwards.
